ps2_key_decoder: RTL

Receives PS/2 keyboard frames, decodes scan-code set 2 make/break sequences, and produces the 7-bit ASCII key value consumed by the note-display and note-playback logic. It sits between the board's PS/2 pins and every block that takes `ascii_val`: it is the producing end of that interface. Only the 19 note keys (Q W E R T Y U I O P A S D F G H J K L) are reported. All other keys are consumed silently.

---
 rtl/ps2_keys_pkg.sv | 83 ++++++++
 rtl/ps2_frame_rx.sv | 94 +++++++++
 rtl/ps2_key_decoder.sv | 65 ++++++
 3 files changed

// File: rtl/ps2_keys_pkg.sv
// rtl/ps2_keys_pkg.sv - state encodings, scan-code/ASCII constants and key lookup for the PS/2 note decoder
package ps2_keys_pkg;

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {DEC_NORMAL, DEC_BREAK, DEC_EXT, DEC_EXT_BREAK} dec_state_t;

  typedef struct packed {
    logic       hit;
    logic [6:0] ascii;
  } key_map_t;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  localparam logic [7:0] SC_Q = 8'h15;
  localparam logic [7:0] SC_W = 8'h1D;
  localparam logic [7:0] SC_E = 8'h24;
  localparam logic [7:0] SC_R = 8'h2D;
  localparam logic [7:0] SC_T = 8'h2C;
  localparam logic [7:0] SC_Y = 8'h35;
  localparam logic [7:0] SC_U = 8'h3C;
  localparam logic [7:0] SC_I = 8'h43;
  localparam logic [7:0] SC_O = 8'h44;
  localparam logic [7:0] SC_P = 8'h4D;
  localparam logic [7:0] SC_A = 8'h1C;
  localparam logic [7:0] SC_S = 8'h1B;
  localparam logic [7:0] SC_D = 8'h23;
  localparam logic [7:0] SC_F = 8'h2B;
  localparam logic [7:0] SC_G = 8'h34;
  localparam logic [7:0] SC_H = 8'h33;
  localparam logic [7:0] SC_J = 8'h3B;
  localparam logic [7:0] SC_K = 8'h42;
  localparam logic [7:0] SC_L = 8'h4B;

  localparam logic [6:0] ASCII_Q = 7'd81;
  localparam logic [6:0] ASCII_W = 7'd87;
  localparam logic [6:0] ASCII_E = 7'd69;
  localparam logic [6:0] ASCII_R = 7'd82;
  localparam logic [6:0] ASCII_T = 7'd84;
  localparam logic [6:0] ASCII_Y = 7'd89;
  localparam logic [6:0] ASCII_U = 7'd85;
  localparam logic [6:0] ASCII_I = 7'd73;
  localparam logic [6:0] ASCII_O = 7'd79;
  localparam logic [6:0] ASCII_P = 7'd80;
  localparam logic [6:0] ASCII_A = 7'd65;
  localparam logic [6:0] ASCII_S = 7'd83;
  localparam logic [6:0] ASCII_D = 7'd68;
  localparam logic [6:0] ASCII_F = 7'd70;
  localparam logic [6:0] ASCII_G = 7'd71;
  localparam logic [6:0] ASCII_H = 7'd72;
  localparam logic [6:0] ASCII_J = 7'd74;
  localparam logic [6:0] ASCII_K = 7'd75;
  localparam logic [6:0] ASCII_L = 7'd76;

  function automatic key_map_t map_scan(input logic [7:0] code);
    key_map_t m;
    m = '{hit: 1'b1, ascii: 7'd0};
    case (code)
      SC_Q: m.ascii = ASCII_Q;
      SC_W: m.ascii = ASCII_W;
      SC_E: m.ascii = ASCII_E;
      SC_R: m.ascii = ASCII_R;
      SC_T: m.ascii = ASCII_T;
      SC_Y: m.ascii = ASCII_Y;
      SC_U: m.ascii = ASCII_U;
      SC_I: m.ascii = ASCII_I;
      SC_O: m.ascii = ASCII_O;
      SC_P: m.ascii = ASCII_P;
      SC_A: m.ascii = ASCII_A;
      SC_S: m.ascii = ASCII_S;
      SC_D: m.ascii = ASCII_D;
      SC_F: m.ascii = ASCII_F;
      SC_G: m.ascii = ASCII_G;
      SC_H: m.ascii = ASCII_H;
      SC_J: m.ascii = ASCII_J;
      SC_K: m.ascii = ASCII_K;
      SC_L: m.ascii = ASCII_L;
      default: m.hit = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 pin synchronizer and 11-bit frame receiver with odd parity and inactivity timeout
module ps2_frame_rx
  import ps2_keys_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       byte_rdy,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES);

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          clk_prev;
  logic          fall;
  logic          dat;
  rx_state_t     state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          parity_ok;
  logic [TW-1:0] tcnt;

  assign fall = clk_prev & ~clk_sync[1];
  assign dat  = dat_sync[1];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_sync  <= 2'b11;
      dat_sync  <= 2'b11;
      clk_prev  <= 1'b1;
      state     <= RX_IDLE;
      bit_cnt   <= 3'd0;
      shift_reg <= 8'd0;
      parity_ok <= 1'b0;
      tcnt      <= '0;
      byte_rdy  <= 1'b0;
      byte_data <= 8'd0;
      frame_err <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
      clk_prev <= clk_sync[1];
      byte_rdy  <= 1'b0;
      frame_err <= 1'b0;

      if (state == RX_IDLE || fall) tcnt <= '0;
      else if (tcnt != T_MAX) tcnt <= tcnt + 1'b1;

      // A stalled frame is abandoned even if an edge arrives in the same cycle.
      if (state != RX_IDLE && tcnt == T_MAX) begin
        state     <= RX_IDLE;
        frame_err <= 1'b1;
      end else if (fall) begin
        case (state)
          RX_IDLE: begin
            if (!dat) begin
              state   <= RX_DATA;
              bit_cnt <= 3'd0;
            end else begin
              frame_err <= 1'b1;
            end
          end
          RX_DATA: begin
            shift_reg <= {dat, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= RX_PARITY;
          end
          RX_PARITY: begin
            parity_ok <= ^{shift_reg, dat};
            state     <= RX_STOP;
          end
          RX_STOP: begin
            if (dat && parity_ok) begin
              byte_rdy  <= 1'b1;
              byte_data <= shift_reg;
            end else begin
              frame_err <= 1'b1;
            end
            state <= RX_IDLE;
          end
          default: state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - scan-code set 2 make/break decoder producing the held note key as ASCII
module ps2_key_decoder
  import ps2_keys_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [6:0] ascii_val,
  output logic       key_valid,
  output logic       frame_err
);

  logic       byte_rdy;
  logic [7:0] byte_data;
  logic       rx_err;
  key_map_t   key;
  dec_state_t dec_state;

  ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clock     (clock),
    .resetn    (resetn),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .byte_rdy  (byte_rdy),
    .byte_data (byte_data),
    .frame_err (rx_err)
  );

  assign key = map_scan(byte_data);

  // frame_err is re-registered so it lands in the same cycle as a decoded key would.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dec_state <= DEC_NORMAL;
      ascii_val <= 7'd0;
      key_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      frame_err <= rx_err;
      if (byte_rdy) begin
        case (dec_state)
          DEC_NORMAL: begin
            if (byte_data == SC_BREAK) dec_state <= DEC_BREAK;
            else if (byte_data == SC_EXT) dec_state <= DEC_EXT;
            else if (key.hit && key.ascii != ascii_val) begin
              ascii_val <= key.ascii;
              key_valid <= 1'b1;
            end
          end
          DEC_BREAK: begin
            if (key.hit && key.ascii == ascii_val) ascii_val <= 7'd0;
            dec_state <= DEC_NORMAL;
          end
          DEC_EXT: dec_state <= (byte_data == SC_BREAK) ? DEC_EXT_BREAK : DEC_NORMAL;
          default: dec_state <= DEC_NORMAL;
        endcase
      end
    end
  end

endmodule
